muldiv_sequencer: RTL

MULDIV_SEQUENCER -- requirements
Module: muldiv_sequencer

---
 rtl/mips_pkg.sv | 31 +++
 rtl/muldiv_datapath.sv | 58 +++++
 rtl/muldiv_sequencer.sv | 133 +++++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit: funct codes,
// sequencer states and operation kinds.
package mips_pkg;

  localparam logic [5:0] FUNCT_MFHI  = 6'b010000;
  localparam logic [5:0] FUNCT_MTHI  = 6'b010001;
  localparam logic [5:0] FUNCT_MFLO  = 6'b010010;
  localparam logic [5:0] FUNCT_MTLO  = 6'b010011;
  localparam logic [5:0] FUNCT_MULT  = 6'b011000;
  localparam logic [5:0] FUNCT_MULTU = 6'b011001;
  localparam logic [5:0] FUNCT_DIV   = 6'b011010;
  localparam logic [5:0] FUNCT_DIVU  = 6'b011011;

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_e;
  typedef enum logic [1:0] {MUL, MULU, DIV, DIVU} op_kind_e;

  function automatic logic is_muldiv(input logic [5:0] funct);
    return (funct == FUNCT_MULT) || (funct == FUNCT_MULTU) ||
           (funct == FUNCT_DIV)  || (funct == FUNCT_DIVU);
  endfunction

  function automatic op_kind_e op_of(input logic [5:0] funct);
    case (funct)
      FUNCT_MULTU: return MULU;
      FUNCT_DIV:   return DIV;
      FUNCT_DIVU:  return DIVU;
      default:     return MUL;
    endcase
  endfunction

endpackage

// File: rtl/muldiv_datapath.sv
// Iterative unsigned shift-add multiplier / restoring divider on magnitudes.
// Multiply: {acc,q} holds the product; divide: q is quotient, acc remainder.
module muldiv_datapath #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic             step_i,
  input  logic             div_i,
  input  logic [WIDTH-1:0] q_init_i,
  input  logic [WIDTH-1:0] m_init_i,
  output logic [WIDTH-1:0] acc_o,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] m_q;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH+1:0] diff;
  logic             ge;

  always_comb begin
    sum    = {1'b0, acc_q} + (q_q[0] ? {1'b0, m_q} : '0);
    rem_sh = {acc_q, q_q[WIDTH-1]};
    diff   = {1'b0, rem_sh} - {2'b00, m_q};
    // rem_sh < 2*m always, so a non-borrowing difference fits in WIDTH bits
    ge     = (diff[WIDTH+1:WIDTH] == 2'b00);
    if (div_i) begin
      acc_d = ge ? diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
      q_d   = {q_q[WIDTH-2:0], ge};
    end else begin
      acc_d = sum[WIDTH:1];
      q_d   = {sum[0], q_q[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q <= '0;
      q_q   <= '0;
      m_q   <= '0;
    end else if (load_i) begin
      acc_q <= '0;
      q_q   <= q_init_i;
      m_q   <= m_init_i;
    end else if (step_i) begin
      acc_q <= acc_d;
      q_q   <= q_d;
    end
  end

  assign acc_o = acc_q;
  assign q_o   = q_q;

endmodule

// File: rtl/muldiv_sequencer.sv
// MIPS HI/LO multiply/divide sequencer: FSM, iteration counter, sign fix-up
// and the HI/LO registers.
//   state | meaning
//   IDLE  | waiting; accepts mult/div start and mthi/mtlo writes
//   RUN   | one datapath iteration per cycle, WIDTH cycles
//   FIX   | sign-correct the magnitudes and write HI/LO
module muldiv_sequencer
  import mips_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [5:0]       funct,
  input  logic [WIDTH-1:0] srca,
  input  logic [WIDTH-1:0] srcb,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  state_e           state_q;
  op_kind_e         op_q, op_in;
  logic [CW-1:0]    cnt_q;
  logic             neg_q, rneg_q;
  logic             busy_q, done_q;
  logic [WIDTH-1:0] hi_q, lo_q;

  logic             start_md, signed_in, a_neg, b_neg, dp_load, dp_div;
  logic [WIDTH-1:0] a_mag, b_mag, q_init, m_init, dp_acc, dp_q;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0] quot_fix, rem_fix;

  always_comb begin
    op_in     = op_of(funct);
    start_md  = start && is_muldiv(funct);
    signed_in = (op_in == MUL) || (op_in == DIV);
    a_neg     = signed_in && srca[WIDTH-1];
    b_neg     = signed_in && srcb[WIDTH-1];
    a_mag     = a_neg ? -srca : srca;
    b_mag     = b_neg ? -srcb : srcb;
    // multiplier shifts through q; dividend shifts out of q
    if ((op_in == MUL) || (op_in == MULU)) begin
      q_init = b_mag;
      m_init = a_mag;
    end else begin
      q_init = a_mag;
      m_init = b_mag;
    end
    dp_load  = (state_q == IDLE) && start_md;
    dp_div   = (op_q == DIV) || (op_q == DIVU);
    prod_fix = neg_q ? -{dp_acc, dp_q} : {dp_acc, dp_q};
    quot_fix = neg_q ? -dp_q : dp_q;
    rem_fix  = rneg_q ? -dp_acc : dp_acc;
  end

  muldiv_datapath #(.WIDTH(WIDTH)) u_datapath (
    .clk      (clk),
    .reset    (reset),
    .load_i   (dp_load),
    .step_i   (state_q == RUN),
    .div_i    (dp_div),
    .q_init_i (q_init),
    .m_init_i (m_init),
    .acc_o    (dp_acc),
    .q_o      (dp_q)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      op_q    <= MUL;
      cnt_q   <= '0;
      neg_q   <= 1'b0;
      rneg_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start_md) begin
            state_q <= RUN;
            busy_q  <= 1'b1;
            cnt_q   <= '0;
            op_q    <= op_in;
            neg_q   <= a_neg ^ b_neg;
            rneg_q  <= a_neg;
          end else if (start && (funct == FUNCT_MTHI)) begin
            hi_q <= srca;
          end else if (start && (funct == FUNCT_MTLO)) begin
            lo_q <= srca;
          end
        end
        RUN: begin
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == CNT_LAST) begin
            state_q <= FIX;
            cnt_q   <= '0;
          end
        end
        FIX: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          if (dp_div) begin
            hi_q <= rem_fix;
            lo_q <= quot_fix;
          end else begin
            {hi_q, lo_q} <= prod_fix;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule
